// File: rtl/freq_meter_ctrl_if.sv
// Frequency-meter control bus. The Gate_Sel line exists only when GATE_SEL_EN is defined.
interface freq_meter_ctrl_if #(
  parameter int unsigned CNT_W = 32
);
  logic             Start;
  logic             Abort;
  logic             Sig_In;
  logic             Gate_Signal;
  logic             Busy;
  logic [CNT_W-1:0] Result;
  logic             Result_Valid;
  logic             Overflow;
`ifdef GATE_SEL_EN
  logic [1:0]       Gate_Sel;
`endif

  modport master (
`ifdef GATE_SEL_EN
    output Gate_Sel,
`endif
    output Start, Abort, Sig_In,
    input  Gate_Signal, Busy, Result, Result_Valid, Overflow
  );

  modport slave (
`ifdef GATE_SEL_EN
    input  Gate_Sel,
`endif
    input  Start, Abort, Sig_In,
    output Gate_Signal, Busy, Result, Result_Valid, Overflow
  );
endinterface

// File: rtl/freq_meter_ctrl.sv
// Gate-window measurement sequencer: counts synchronised rising edges of Sig_In over GATE_CYCLES clocks.
// Optional GATE_SEL_EN adds Gate_Sel to pick GATE_CYCLES / 1, 10, 100 or 1000.
module freq_meter_ctrl #(
  parameter int unsigned GATE_CYCLES = 100000000,
  parameter int unsigned CNT_W       = 32
) (
  input logic                Clk,
  input logic                Rst_n,
  freq_meter_ctrl_if.slave   bus
);

  localparam int unsigned GW = 28;
  localparam logic [GW-1:0] LIM0 = GW'(GATE_CYCLES);

  typedef enum logic [1:0] {IDLE, ARM, GATE, DONE} state_t;

  state_t           state, next_state;
  logic             sync1, sync2, sync3;
  logic             edge_det;
  logic [GW-1:0]    gate_cnt, gate_nxt;
  logic [CNT_W-1:0] edge_cnt, edge_nxt;
  logic             ovf, ovf_nxt;
  logic             gate_q;
  logic [CNT_W-1:0] result_q;
  logic             overflow_q;
  logic             busy, result_valid;
  logic [GW-1:0]    limit;

`ifdef GATE_SEL_EN
  // Divided lengths are clamped to one cycle so the terminal compare never underflows.
  localparam logic [GW-1:0] LIM1 = GW'((GATE_CYCLES / 10)   > 0 ? (GATE_CYCLES / 10)   : 1);
  localparam logic [GW-1:0] LIM2 = GW'((GATE_CYCLES / 100)  > 0 ? (GATE_CYCLES / 100)  : 1);
  localparam logic [GW-1:0] LIM3 = GW'((GATE_CYCLES / 1000) > 0 ? (GATE_CYCLES / 1000) : 1);

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      limit <= '0;
    end else if (state == ARM) begin
      case (bus.Gate_Sel)
        2'd0:    limit <= LIM0;
        2'd1:    limit <= LIM1;
        2'd2:    limit <= LIM2;
        default: limit <= LIM3;
      endcase
    end
  end
`else
  assign limit = LIM0;
`endif

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      sync3 <= 1'b0;
    end else begin
      sync1 <= bus.Sig_In;
      sync2 <= sync1;
      sync3 <= sync2;
    end
  end

  assign edge_det = sync2 & ~sync3;

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) state <= IDLE;
    else        state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE: if (bus.Start) next_state = ARM;
      ARM:  next_state = bus.Abort ? IDLE : GATE;
      GATE: begin
        if (bus.Abort)                           next_state = IDLE;
        else if (gate_cnt == limit - GW'(1))     next_state = DONE;
      end
      DONE: next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_comb begin
    busy         = (state != IDLE);
    result_valid = (state == DONE);
  end

  always_comb begin
    gate_nxt = gate_cnt;
    edge_nxt = edge_cnt;
    ovf_nxt  = ovf;
    case (state)
      ARM: begin
        gate_nxt = '0;
        edge_nxt = '0;
        ovf_nxt  = 1'b0;
      end
      GATE: begin
        gate_nxt = gate_cnt + GW'(1);
        if (edge_det) begin
          if (&edge_cnt) ovf_nxt  = 1'b1;
          else           edge_nxt = edge_cnt + CNT_W'(1);
        end
      end
      default: ;
    endcase
  end

  // Result is captured from the next-count value on entry to DONE so it is
  // already valid during the DONE cycle that drives Result_Valid.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      gate_cnt   <= '0;
      edge_cnt   <= '0;
      ovf        <= 1'b0;
      gate_q     <= 1'b0;
      result_q   <= '0;
      overflow_q <= 1'b0;
    end else begin
      gate_cnt <= gate_nxt;
      edge_cnt <= edge_nxt;
      ovf      <= ovf_nxt;
      gate_q   <= (next_state == GATE);
      if (state == GATE && next_state == DONE) begin
        result_q   <= edge_nxt;
        overflow_q <= ovf_nxt;
      end
    end
  end

  assign bus.Gate_Signal  = gate_q;
  assign bus.Busy         = busy;
  assign bus.Result       = result_q;
  assign bus.Result_Valid = result_valid;
  assign bus.Overflow     = overflow_q;

endmodule

// File: tb/tb_freq_meter_ctrl.sv
// Bench for freq_meter_ctrl: two instances (20-cycle/32-bit and 40-cycle/4-bit gates) share one test signal.
// A third 1000-cycle instance exercises Gate_Sel when GATE_SEL_EN is defined.
module tb_freq_meter_ctrl;

  logic Clk = 1'b0;
  logic Rst_n = 1'b0;
  always #5 Clk = ~Clk;

  freq_meter_ctrl_if #(.CNT_W(32)) bus_a ();
  freq_meter_ctrl_if #(.CNT_W(4))  bus_b ();

  freq_meter_ctrl #(.GATE_CYCLES(20), .CNT_W(32)) dut_a (.Clk(Clk), .Rst_n(Rst_n), .bus(bus_a));
  freq_meter_ctrl #(.GATE_CYCLES(40), .CNT_W(4))  dut_b (.Clk(Clk), .Rst_n(Rst_n), .bus(bus_b));

`ifdef GATE_SEL_EN
  freq_meter_ctrl_if #(.CNT_W(32)) bus_c ();
  freq_meter_ctrl #(.GATE_CYCLES(1000), .CNT_W(32)) dut_c (.Clk(Clk), .Rst_n(Rst_n), .bus(bus_c));
`endif

  typedef struct {
    int unsigned half;
    int unsigned ea;
    bit          oa;
    int unsigned eb;
    bit          ob;
  } vec_t;

  int unsigned vec_count = 0;
  int unsigned miscompares = 0;
  int unsigned n = 0;
  bit          hist[$];
  bit          sig = 1'b0;
  bit          rnd = 1'b0;
  int unsigned half = 0;
  vec_t        tab[5];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vec_count++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic drive_sig();
    bus_a.Sig_In = sig;
    bus_b.Sig_In = sig;
`ifdef GATE_SEL_EN
    bus_c.Sig_In = sig;
`endif
  endtask

  // hist[k] is the Sig_In value present at posedge number k.
  task automatic tick();
    @(posedge Clk);
    hist.push_back(sig);
    n++;
    #1;
    if (rnd)           sig = 1'($urandom_range(0, 1));
    else if (half == 0) sig = 1'b0;
    else               sig = ((n / half) % 2) == 1;
    drive_sig();
  endtask

  task automatic warm(input int unsigned cycles);
    for (int unsigned i = 0; i < cycles; i++) tick();
  endtask

  // Reference: a rising edge of Sig_In between samples k-1 and k falls in a
  // measurement started at edge s of length len when s <= k < s+len
  // (the synchroniser delay shifts the window by exactly the Start sample).
  function automatic int unsigned model_count(input int unsigned s, input int unsigned len);
    int unsigned c = 0;
    for (int unsigned k = s; k < s + len; k++)
      if (k >= 1 && hist[k] && !hist[k-1]) c++;
    return c;
  endfunction

  // Result_Valid is expected G+2 edges after Start is presented: the IDLE sample
  // cycle, ARM, G gate cycles and DONE make G+3 cycles counting the IDLE one.
  task automatic measure(input bit use_tab, input vec_t v);
    int unsigned s, ga, gb, va, vb, ma, mb;
    int          lat_a, lat_b;
    logic [31:0] ra, rb, ea, eb;
    logic        oa, ob, xa, xb;
    ga = 0; gb = 0; va = 0; vb = 0;
    lat_a = -1; lat_b = -1;
    ra = '0; rb = '0; oa = 1'b0; ob = 1'b0;
    s = n;
    bus_a.Start = 1'b1;
    bus_b.Start = 1'b1;
    for (int i = 1; i <= 60; i++) begin
      tick();
      bus_a.Start = 1'b0;
      bus_b.Start = 1'b0;
      if (bus_a.Gate_Signal) ga++;
      if (bus_b.Gate_Signal) gb++;
      if (bus_a.Result_Valid) begin
        va++;
        if (lat_a < 0) lat_a = i;
        ra = bus_a.Result;
        oa = bus_a.Overflow;
      end
      if (bus_b.Result_Valid) begin
        vb++;
        if (lat_b < 0) lat_b = i;
        rb = 32'(bus_b.Result);
        ob = bus_b.Overflow;
      end
    end
    ma = model_count(s, 20);
    mb = model_count(s, 40);
    ea = use_tab ? v.ea : ma;
    xa = use_tab ? v.oa : 1'b0;
    eb = use_tab ? v.eb : ((mb > 15) ? 15 : mb);
    xb = use_tab ? v.ob : (mb > 15);
    chk("a_latency",    32'(lat_a), 32'd22);
    chk("a_gate_width", ga, 32'd20);
    chk("a_valid_once", va, 32'd1);
    chk("a_result",     ra, ea);
    chk("a_overflow",   32'(oa), 32'(xa));
    chk("b_latency",    32'(lat_b), 32'd42);
    chk("b_gate_width", gb, 32'd40);
    chk("b_valid_once", vb, 32'd1);
    chk("b_result",     rb, eb);
    chk("b_overflow",   32'(ob), 32'(xb));
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int unsigned vcnt;
    logic        bsy[1:60];
    logic        vld[1:60];

    tab[0] = '{half: 1,  ea: 10, oa: 1'b0, eb: 15, ob: 1'b1};
    tab[1] = '{half: 5,  ea: 2,  oa: 1'b0, eb: 4,  ob: 1'b0};
    tab[2] = '{half: 10, ea: 1,  oa: 1'b0, eb: 2,  ob: 1'b0};
    tab[3] = '{half: 0,  ea: 0,  oa: 1'b0, eb: 0,  ob: 1'b0};
    tab[4] = '{half: 2,  ea: 5,  oa: 1'b0, eb: 10, ob: 1'b0};

    bus_a.Start = 1'b0; bus_a.Abort = 1'b0;
    bus_b.Start = 1'b0; bus_b.Abort = 1'b0;
`ifdef GATE_SEL_EN
    bus_a.Gate_Sel = 2'd0;
    bus_b.Gate_Sel = 2'd0;
    bus_c.Gate_Sel = 2'd0;
    bus_c.Start = 1'b0; bus_c.Abort = 1'b0;
`endif
    drive_sig();

    warm(3);
    chk("rst_busy",     32'(bus_a.Busy), 32'd0);
    chk("rst_gate",     32'(bus_a.Gate_Signal), 32'd0);
    chk("rst_result",   bus_a.Result, 32'd0);
    chk("rst_valid",    32'(bus_a.Result_Valid), 32'd0);
    chk("rst_overflow", 32'(bus_b.Overflow), 32'd0);
    Rst_n = 1'b1;

    foreach (tab[i]) begin
      half = tab[i].half;
      warm(8);
      measure(1'b1, tab[i]);
    end

    // Abort on the 10th gate cycle; previous Result (5) must survive.
    bus_a.Start = 1'b1;
    tick();
    bus_a.Start = 1'b0;
    warm(10);
    chk("abort_pre_gate", 32'(bus_a.Gate_Signal), 32'd1);
    bus_a.Abort = 1'b1;
    tick();
    bus_a.Abort = 1'b0;
    chk("abort_gate_low", 32'(bus_a.Gate_Signal), 32'd0);
    chk("abort_busy",     32'(bus_a.Busy), 32'd0);
    chk("abort_valid",    32'(bus_a.Result_Valid), 32'd0);
    chk("abort_result",   bus_a.Result, 32'd5);
    vcnt = 0;
    for (int i = 0; i < 30; i++) begin
      tick();
      if (bus_a.Result_Valid) vcnt++;
    end
    chk("abort_no_valid", vcnt, 32'd0);

    // Start and Abort together in IDLE: Start wins.
    bus_a.Start = 1'b1;
    bus_a.Abort = 1'b1;
    tick();
    bus_a.Start = 1'b0;
    bus_a.Abort = 1'b0;
    chk("start_wins_busy", 32'(bus_a.Busy), 32'd1);
    vcnt = 0;
    for (int i = 0; i < 30; i++) begin
      tick();
      if (bus_a.Result_Valid) begin
        vcnt++;
        chk("start_wins_result", bus_a.Result, 32'd5);
      end
    end
    chk("start_wins_valid", vcnt, 32'd1);

    // Back-to-back with Start held and Sig_In low.
    half = 0;
    warm(8);
    bus_a.Start = 1'b1;
    vcnt = 0;
    for (int i = 1; i <= 60; i++) begin
      tick();
      bsy[i] = bus_a.Busy;
      vld[i] = bus_a.Result_Valid;
      if (bus_a.Result_Valid) begin
        vcnt++;
        chk("b2b_result", bus_a.Result, 32'd0);
      end
    end
    bus_a.Start = 1'b0;
    chk("b2b_valid_count", vcnt, 32'd2);
    for (int i = 1; i <= 58; i++) begin
      if (vld[i]) begin
        chk("b2b_idle_gap", 32'(bsy[i+1]), 32'd0);
        chk("b2b_rearm",    32'(bsy[i+2]), 32'd1);
      end
    end
    warm(30);

    // Asynchronous reset between clock edges in the middle of a gate.
    half = 2;
    warm(8);
    measure(1'b1, tab[4]);
    bus_a.Start = 1'b1;
    bus_b.Start = 1'b1;
    tick();
    bus_a.Start = 1'b0;
    bus_b.Start = 1'b0;
    warm(6);
    #2;
    Rst_n = 1'b0;
    #1;
    chk("arst_gate",     32'(bus_a.Gate_Signal), 32'd0);
    chk("arst_busy",     32'(bus_a.Busy), 32'd0);
    chk("arst_result",   bus_a.Result, 32'd0);
    chk("arst_valid",    32'(bus_a.Result_Valid), 32'd0);
    chk("arst_overflow", 32'(bus_a.Overflow), 32'd0);
    chk("arst_b_result", 32'(bus_b.Result), 32'd0);
    chk("arst_b_busy",   32'(bus_b.Busy), 32'd0);
    tick();
    Rst_n = 1'b1;
    warm(4);

`ifdef GATE_SEL_EN
    begin
      int unsigned s, g, vc;
      int          lat;
      logic [31:0] r;
      g = 0; vc = 0; lat = -1; r = '0;
      bus_c.Gate_Sel = 2'd2;
      warm(8);
      s = n;
      bus_c.Start = 1'b1;
      for (int i = 1; i <= 20; i++) begin
        tick();
        bus_c.Start = 1'b0;
        if (i == 4) bus_c.Gate_Sel = 2'd0;
        if (bus_c.Gate_Signal) g++;
        if (bus_c.Result_Valid) begin
          vc++;
          if (lat < 0) lat = i;
          r = bus_c.Result;
        end
      end
      chk("sel_gate_width", g, 32'd10);
      chk("sel_latency",    32'(lat), 32'd12);
      chk("sel_valid_once", vc, 32'd1);
      chk("sel_result",     r, model_count(s, 10));
      chk("sel_range",      32'(r == 2 || r == 3), 32'd1);
      bus_c.Gate_Sel = 2'd0;
    end
`endif

    // Randomised signal and Start spacing against the reference model.
    rnd = 1'b1;
    for (int m = 0; m < 12; m++) begin
      warm(2 + $urandom_range(0, 5));
      measure(1'b0, tab[0]);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vec_count, miscompares);
    $finish;
  end

endmodule

// File: doc/freq_meter_ctrl.md
Name: freq_meter_ctrl

Overview:
- Measurement sequencer for the frequency meter. It owns the gate window: it generates a gate of exactly GATE_CYCLES system clocks and counts rising edges of an external signal during that window.
- It latches the count as the result, pulses a valid strobe, and reports overflow.
- It sits between the user/display logic (Start, Abort, Result) and the raw test signal input.

Parameters:
- GATE_CYCLES, 100000000, gate length in Clk cycles (1 s at 100 MHz); legal range 2 to 2^28-1.
- CNT_W, 32, width of the edge counter and Result.

Ports:
- Clk  input  1  system clock, 100 MHz.
- Rst_n  input  1  asynchronous active-low reset.
- Start  input  1  request one measurement; level sampled each cycle.
- Abort  input  1  cancel the measurement in progress.
- Sig_In  input  1  asynchronous signal under test.
- Gate_Signal  output  1  high while the gate window is open.
- Busy  output  1  high in any state other than IDLE.
- Result  output  CNT_W  edge count of the last completed measurement.
- Result_Valid  output  1  one-cycle strobe when Result updates.
- Overflow  output  1  the last completed measurement saturated.

Behaviour:
- Clock and reset: one clock, Clk. Rst_n is asynchronous and active-low. Every register clears on reset assertion: state=IDLE, all outputs 0, counters 0, synchronizer 0.
- Input conditioning: Sig_In passes through a 2-FF synchronizer, then an edge register. Edge_Det = sync2 & ~sync3, giving at most one detection per 2 cycles. Sig_In is never used unsynchronized.
- FSM states: IDLE, ARM, GATE, DONE.
- IDLE:
  - Start=1 moves to ARM on the next edge.
  - Abort has no effect.
- ARM (1 cycle):
  - Clears the edge counter, the gate counter and the internal overflow bit.
  - Next state is GATE.
- GATE:
  - Gate_Signal=1, registered, asserted in exactly the GATE_CYCLES cycles that the FSM spends in GATE.
  - The gate counter increments each cycle. When it reaches GATE_CYCLES-1, the FSM moves to DONE and Gate_Signal drops.
  - Each cycle in GATE with Edge_Det=1 increments the edge counter.
  - Edge counter saturation: at all-ones it holds, and a further edge sets the internal overflow bit. It never wraps.
- DONE (1 cycle):
  - Result <= edge count, Overflow <= internal overflow, Result_Valid=1.
  - Next state is IDLE.
  - Result and Overflow hold until the next DONE.
- Start: Start held high re-arms immediately. DONE goes to IDLE, and IDLE goes to ARM on the next cycle.
- Latency: from Start sampled in IDLE to Result_Valid is GATE_CYCLES+3 cycles (ARM, GATE, DONE, plus the IDLE sample).
- Abort in ARM or GATE:
  - Next state is IDLE and Gate_Signal goes low.
  - No Result_Valid; Result and Overflow keep their old values.
- Abort in DONE: the strobe completes and Abort is ignored.
- Simultaneous Start and Abort in IDLE: Start wins. Abort is only meaningful when Busy=1.
- Edges arriving in the 3 cycles before the gate closes that have not yet reached Edge_Det are not counted. This is a fixed, documented ±1 count quantisation.
- Reset mid-measurement: immediate return to IDLE with all outputs 0. The previous Result is lost.

Optional Feature:
- Macro: GATE_SEL_EN.
- When defined:
  - Adds input Gate_Sel[1:0]. Values 0, 1, 2, 3 select GATE_CYCLES, GATE_CYCLES/10, GATE_CYCLES/100, GATE_CYCLES/1000 (integer division, each computed at elaboration).
  - Gate_Sel is sampled in ARM only and held for the whole measurement; changes during GATE are ignored.
- When undefined: no Gate_Sel port, and the gate is always GATE_CYCLES.

Test Plan:
- Basic count, GATE_CYCLES=20, CNT_W=32:
  - Stimulus: Sig_In toggles every 2 clocks (period 4), running well before Start; pulse Start 1 cycle.
  - Required: Gate_Signal high exactly 20 cycles; Result_Valid pulses once, 23 cycles after the Start sample; Result=5; Overflow=0.
- Saturation, GATE_CYCLES=40, CNT_W=4:
  - Stimulus: Sig_In toggles every clock (period 2).
  - Required: Result=15, Overflow=1.
- Abort:
  - Stimulus: Start, then Abort at cycle 10 of GATE.
  - Required: Gate_Signal low next cycle, Busy=0, no Result_Valid, Result still holds the prior value of 5.
- Back-to-back with Sig_In=0 constant:
  - Stimulus: Start held high for 60 cycles.
  - Required: consecutive measurements with exactly 1 IDLE cycle between DONE and ARM; each Result=0 with Result_Valid.
- Async reset:
  - Stimulus: assert Rst_n=0 mid-GATE, between clock edges.
  - Required: Gate_Signal, Busy, Result, Result_Valid, Overflow all 0 immediately, without waiting for a clock edge.
- GATE_SEL_EN defined, GATE_CYCLES=1000:
  - Stimulus: Gate_Sel=2, Sig_In period 4.
  - Required: gate is 10 cycles, Result=2 or 3 depending on phase; changing Gate_Sel during GATE has no effect.
